enigma_stepper: RTL and testbench
=================================

Name: enigma_stepper

Overview:
- Rotor stepping unit for the Enigma I datapath.
- Holds the current left/middle/right rotor positions and advances them on each keypress, including the middle-rotor double-step anomaly.
- Sits directly upstream of the forward cipher path and drives its pos_l/pos_m/pos_r inputs.
- The cipher FSM pulses step_req before each CIPHER_A phase and waits for step_done.

Parameters:
- COUNT_W, 16, width of the keypress counter (wraps modulo 2^COUNT_W).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- rotor_sel_l  input  3  left rotor selection (0=I..4=V)
- rotor_sel_m  input  3  middle rotor selection
- rotor_sel_r  input  3  right rotor selection
- load  input  1  single-cycle request to load start positions
- load_pos_l  input  5  left start position
- load_pos_m  input  5  middle start position
- load_pos_r  input  5  right start position
- step_req  input  1  single-cycle request to advance rotors once
- pos_l  output  5  registered left position 0..25
- pos_m  output  5  registered middle position 0..25
- pos_r  output  5  registered right position 0..25
- step_done  output  1  one-cycle pulse: positions now reflect the requested step
- key_count  output  COUNT_W  number of steps since last load/reset

Behaviour:
- Interface: one clock; reset is synchronous and active-low, sampled on the rising edge of clk.
- Reset (rst_n=0 at an edge): pos_l=pos_m=pos_r=0, step_done=0, key_count=0. Reset mid-operation discards any pending step_req/load in that cycle.
- Notch table, indexed by rotor selection, gives the turnover position:
  - I=16 (Q), II=4 (E), III=21 (V), IV=9 (J), V=25 (Z).
  - Selections 5..7 have no notch and never cause turnover.
- notch_r = (pos_r == notch(rotor_sel_r)); notch_m = (pos_m == notch(rotor_sel_m)). Both are evaluated on the pre-step registered positions.
- Step (step_req=1, load=0, rst_n=1 at edge N), single-cycle latency:
  - pos_r <= pos_r+1 mod 26, always.
  - pos_m <= pos_m+1 mod 26 if notch_r OR notch_m. The notch_m term is the double step.
  - pos_l <= pos_l+1 mod 26 if notch_m.
  - key_count <= key_count+1, wrapping.
  - step_done=1 during the cycle after edge N, then 0 unless another step is accepted.
- Increment mod 26: a value of 25 wraps to 0. No other arithmetic is performed; registers never hold 26..31.
- Back-to-back step_req on consecutive cycles is legal: one step per cycle, and step_done stays high for each accepted step.
- Load (load=1 at edge):
  - Each pos_x <= load_pos_x if <=25, else load_pos_x-26. Values 26..31 fold to 0..5.
  - key_count <= 0; step_done <= 0.
- Simultaneous load and step_req: load wins, the step is dropped, step_done=0.
- rotor_sel_* are sampled combinationally at the stepping edge. Changing them between steps alters only subsequent notch evaluation, never the held positions.
- Idle (no load, no step): all registers hold; step_done=0.
- No internal FSM beyond the registered step_done flag. The controller must not issue step_req until it has consumed pos_* for the previous letter.

Test Plan:
- Reset, rotors I-II-III, load 0,0,0, one step_req -> next cycle pos=(0,0,1), step_done=1 for exactly one cycle, key_count=1.
- Rotors I-II-III, load (0,3,20) "ADU", three consecutive step_req -> (0,3,21), (0,4,22), then double step to (1,5,23) "BFX"; key_count=3.
- Rotors III-IV-V, load (0,0,25), step -> (0,1,0): right wraps and its Z notch turns the middle rotor.
- Selections 7,7,7, load (0,0,21), 30 steps -> pos_m and pos_l stay 0, pos_r=(21+30) mod 26=25, key_count=30.
- load=1 and step_req=1 in the same cycle with load values (2,31,26) -> pos=(2,5,0), step_done=0, key_count=0.
- After 5 steps from (0,0,0), assert rst_n=0 for one edge concurrent with step_req -> pos=(0,0,0), step_done=0, key_count=0.

Source files
------------

// File: rtl/enigma_stepper.sv
// Enigma I rotor stepping unit: holds left/middle/right rotor positions and
// advances them once per accepted keypress, including the middle-rotor
// double step. Positions are always kept in 0..25.
module enigma_stepper #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         rotor_sel_l,
    input  logic [2:0]         rotor_sel_m,
    input  logic [2:0]         rotor_sel_r,
    input  logic               load,
    input  logic [4:0]         load_pos_l,
    input  logic [4:0]         load_pos_m,
    input  logic [4:0]         load_pos_r,
    input  logic               step_req,
    output logic [4:0]         pos_l,
    output logic [4:0]         pos_m,
    output logic [4:0]         pos_r,
    output logic               step_done,
    output logic [COUNT_W-1:0] key_count
);

    logic [4:0]         pos_l_q, pos_l_d;
    logic [4:0]         pos_m_q, pos_m_d;
    logic [4:0]         pos_r_q, pos_r_d;
    logic               step_done_q, step_done_d;
    logic [COUNT_W-1:0] key_count_q, key_count_d;
    logic               notch_r, notch_m;

    // True when pos sits on the turnover letter of rotor sel; 5..7 never turn over.
    function automatic logic at_notch(input logic [2:0] sel, input logic [4:0] pos);
        case (sel)
            3'd0:    at_notch = (pos == 5'd16);
            3'd1:    at_notch = (pos == 5'd4);
            3'd2:    at_notch = (pos == 5'd21);
            3'd3:    at_notch = (pos == 5'd9);
            3'd4:    at_notch = (pos == 5'd25);
            default: at_notch = 1'b0;
        endcase
    endfunction

    function automatic logic [4:0] inc26(input logic [4:0] p);
        inc26 = (p == 5'd25) ? 5'd0 : p + 5'd1;
    endfunction

    // Load values 26..31 fold back onto 0..5.
    function automatic logic [4:0] fold26(input logic [4:0] p);
        fold26 = (p > 5'd25) ? p - 5'd26 : p;
    endfunction

    // The left rotor's notch plays no part in stepping; its selection is unused.
    logic unused_sel_l;
    assign unused_sel_l = ^rotor_sel_l;

    assign notch_r = at_notch(rotor_sel_r, pos_r_q);
    assign notch_m = at_notch(rotor_sel_m, pos_m_q);

    // Next-state: load beats step; a middle rotor on its notch steps itself (double step).
    always_comb begin
        pos_l_d     = pos_l_q;
        pos_m_d     = pos_m_q;
        pos_r_d     = pos_r_q;
        key_count_d = key_count_q;
        step_done_d = 1'b0;
        if (load) begin
            pos_l_d     = fold26(load_pos_l);
            pos_m_d     = fold26(load_pos_m);
            pos_r_d     = fold26(load_pos_r);
            key_count_d = '0;
        end else if (step_req) begin
            pos_r_d = inc26(pos_r_q);
            if (notch_r || notch_m) pos_m_d = inc26(pos_m_q);
            if (notch_m)            pos_l_d = inc26(pos_l_q);
            key_count_d = key_count_q + 1'b1;
            step_done_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_l_q     <= '0;
            pos_m_q     <= '0;
            pos_r_q     <= '0;
            step_done_q <= 1'b0;
            key_count_q <= '0;
        end else begin
            pos_l_q     <= pos_l_d;
            pos_m_q     <= pos_m_d;
            pos_r_q     <= pos_r_d;
            step_done_q <= step_done_d;
            key_count_q <= key_count_d;
        end
    end

    assign pos_l     = pos_l_q;
    assign pos_m     = pos_m_q;
    assign pos_r     = pos_r_q;
    assign step_done = step_done_q;
    assign key_count = key_count_q;

endmodule

// File: tb/tb_enigma_stepper.sv
// Bench for enigma_stepper: directed scenarios then random traffic, all
// compared against a letter-level rotor model.
module tb_enigma_stepper;
    localparam int COUNT_W = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [2:0]         rotor_sel_l, rotor_sel_m, rotor_sel_r;
    logic               load, step_req;
    logic [4:0]         load_pos_l, load_pos_m, load_pos_r;
    logic [4:0]         pos_l, pos_m, pos_r;
    logic               step_done;
    logic [COUNT_W-1:0] key_count;

    enigma_stepper #(.COUNT_W(COUNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rotor_sel_l(rotor_sel_l), .rotor_sel_m(rotor_sel_m), .rotor_sel_r(rotor_sel_r),
        .load(load), .load_pos_l(load_pos_l), .load_pos_m(load_pos_m), .load_pos_r(load_pos_r),
        .step_req(step_req),
        .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r),
        .step_done(step_done), .key_count(key_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: rotor positions as letters, turnover letters per rotor.
    int notch_tab [8] = '{16, 4, 21, 9, 25, -1, -1, -1};
    int m_l, m_m, m_r, m_cnt, m_done;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit ld, input bit st,
                              input int ll, input int lm, input int lr);
        bit turn_r, turn_m;
        if (!r) begin
            m_l = 0; m_m = 0; m_r = 0; m_cnt = 0; m_done = 0;
        end else if (ld) begin
            m_l = ll % 26; m_m = lm % 26; m_r = lr % 26; m_cnt = 0; m_done = 0;
        end else if (st) begin
            turn_r = (m_r == notch_tab[rotor_sel_r]);
            turn_m = (m_m == notch_tab[rotor_sel_m]);
            m_r = (m_r + 1) % 26;
            if (turn_r || turn_m) m_m = (m_m + 1) % 26;
            if (turn_m)           m_l = (m_l + 1) % 26;
            m_cnt = (m_cnt + 1) % (1 << COUNT_W);
            m_done = 1;
        end else begin
            m_done = 0;
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
    task automatic cyc(input bit r, input bit ld, input bit st,
                       input int ll, input int lm, input int lr);
        rst_n = r; load = ld; step_req = st;
        load_pos_l = 5'(ll); load_pos_m = 5'(lm); load_pos_r = 5'(lr);
        @(posedge clk);
        model_edge(r, ld, st, ll, lm, lr);
        #1;
        chk("pos_l", int'(pos_l), m_l);
        chk("pos_m", int'(pos_m), m_m);
        chk("pos_r", int'(pos_r), m_r);
        chk("step_done", int'(step_done), m_done);
        chk("key_count", int'(key_count), m_cnt);
    endtask

    task automatic sel(input int l, input int m, input int r);
        rotor_sel_l = 3'(l); rotor_sel_m = 3'(m); rotor_sel_r = 3'(r);
    endtask

    initial begin
        m_l = 0; m_m = 0; m_r = 0; m_cnt = 0; m_done = 0;
        sel(0, 1, 2);
        #2;
        // Reset, I-II-III, load AAA, one step.
        cyc(0, 0, 1, 0, 0, 0);
        chk("rst_key_count", int'(key_count), 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        chk("first_step_pos_r", int'(pos_r), 1);
        chk("first_step_done", int'(step_done), 1);
        cyc(1, 0, 0, 0, 0, 0);
        chk("done_one_cycle", int'(step_done), 0);

        // Double step ADU -> ADV -> AEW -> BFX.
        cyc(1, 1, 0, 0, 3, 20);
        repeat (3) cyc(1, 0, 1, 0, 0, 0);
        chk("dbl_pos_l", int'(pos_l), 1);
        chk("dbl_pos_m", int'(pos_m), 5);
        chk("dbl_pos_r", int'(pos_r), 23);
        chk("dbl_count", int'(key_count), 3);

        // III-IV-V: right at Z wraps and turns middle.
        sel(2, 3, 4);
        cyc(1, 1, 0, 0, 0, 25);
        cyc(1, 0, 1, 0, 0, 0);
        chk("z_wrap_m", int'(pos_m), 1);
        chk("z_wrap_r", int'(pos_r), 0);

        // No-notch selections: 30 steps only move the right rotor.
        sel(7, 7, 7);
        cyc(1, 1, 0, 0, 0, 21);
        repeat (30) cyc(1, 0, 1, 0, 0, 0);
        chk("nonotch_m", int'(pos_m), 0);
        chk("nonotch_r", int'(pos_r), 25);
        chk("nonotch_count", int'(key_count), 30);

        // Load beats step, values fold.
        sel(0, 1, 2);
        cyc(1, 1, 1, 2, 31, 26);
        chk("ldstep_m", int'(pos_m), 5);
        chk("ldstep_done", int'(step_done), 0);

        // Reset concurrent with step after 5 steps.
        cyc(1, 1, 0, 0, 0, 0);
        repeat (5) cyc(1, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("rst_mid_r", int'(pos_r), 0);
        chk("rst_mid_done", int'(step_done), 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r, ld, st;
            if ($urandom_range(0, 7) == 0)
                sel($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            r  = ($urandom_range(0, 99) != 0);
            ld = ($urandom_range(0, 19) == 0);
            st = ($urandom_range(0, 3) != 0);
            cyc(r, ld, st, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
